// File: rtl/acc_arbiter.sv
// Round-robin arbiter sharing one accelerator request/response port among NumReq requesters.
// Grants are held while the accelerator stalls; per-requester counters limit in-flight requests.
module acc_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AccAddrWidth   = 5,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxWidth      = $clog2(NumReq),
  localparam int unsigned OutIdWidth    = IdWidth + IdxWidth
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NumReq-1:0][AccAddrWidth-1:0]       slv_q_addr,
  input  logic [NumReq-1:0][31:0]                   slv_q_op,
  input  logic [NumReq-1:0][DataWidth-1:0]          slv_q_arga,
  input  logic [NumReq-1:0][DataWidth-1:0]          slv_q_argb,
  input  logic [NumReq-1:0][DataWidth-1:0]          slv_q_argc,
  input  logic [NumReq-1:0][IdWidth-1:0]            slv_q_id,
  input  logic [NumReq-1:0]                         slv_q_valid,
  output logic [NumReq-1:0]                         slv_q_ready,
  output logic [NumReq-1:0][DataWidth-1:0]          slv_p_data,
  output logic [NumReq-1:0][IdWidth-1:0]            slv_p_id,
  output logic [NumReq-1:0]                         slv_p_error,
  output logic [NumReq-1:0]                         slv_p_valid,
  input  logic [NumReq-1:0]                         slv_p_ready,
  output logic [AccAddrWidth-1:0]                   mst_q_addr,
  output logic [31:0]                               mst_q_op,
  output logic [DataWidth-1:0]                      mst_q_arga,
  output logic [DataWidth-1:0]                      mst_q_argb,
  output logic [DataWidth-1:0]                      mst_q_argc,
  output logic [OutIdWidth-1:0]                     mst_q_id,
  output logic                                      mst_q_valid,
  input  logic                                      mst_q_ready,
  input  logic [DataWidth-1:0]                      mst_p_data,
  input  logic [OutIdWidth-1:0]                     mst_p_id,
  input  logic                                      mst_p_error,
  input  logic                                      mst_p_valid,
  output logic                                      mst_p_ready
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumReq - 1);

  logic [IdxWidth-1:0]              r_ptr;
  logic                             r_lock;
  logic [IdxWidth-1:0]              r_lock_idx;
  logic [NumReq-1:0][CntWidth-1:0]  r_cnt;

  logic [NumReq-1:0]   w_eligible;
  logic                w_hi_any, w_lo_any;
  logic [IdxWidth-1:0] w_hi_idx, w_lo_idx;
  logic                w_gnt_any;
  logic [IdxWidth-1:0] w_gnt_idx;
  logic                w_q_hs;
  logic [IdxWidth-1:0] w_p_idx;
  logic                w_p_in_range;
  logic                w_p_hs;
  logic [NumReq-1:0]   w_inc, w_dec;

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      w_eligible[i] = slv_q_valid[i] && (r_cnt[i] != MaxCnt);
    end
  end

  // Two-pass priority search: lowest eligible index at or above the pointer, else lowest overall.
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_idx = '0;
    w_lo_any = 1'b0;
    w_lo_idx = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_lo_any = 1'b1;
        w_lo_idx = IdxWidth'(i);
        if (i >= int'(r_ptr)) begin
          w_hi_any = 1'b1;
          w_hi_idx = IdxWidth'(i);
        end
      end
    end
  end

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = r_ptr;
    if (r_lock) begin
      w_gnt_any = 1'b1;
      w_gnt_idx = r_lock_idx;
    end else if (w_hi_any) begin
      w_gnt_any = 1'b1;
      w_gnt_idx = w_hi_idx;
    end else if (w_lo_any) begin
      w_gnt_any = 1'b1;
      w_gnt_idx = w_lo_idx;
    end
  end

  assign mst_q_valid = w_gnt_any && w_eligible[w_gnt_idx];
  assign mst_q_addr  = slv_q_addr[w_gnt_idx];
  assign mst_q_op    = slv_q_op[w_gnt_idx];
  assign mst_q_arga  = slv_q_arga[w_gnt_idx];
  assign mst_q_argb  = slv_q_argb[w_gnt_idx];
  assign mst_q_argc  = slv_q_argc[w_gnt_idx];
  assign mst_q_id    = {w_gnt_idx, slv_q_id[w_gnt_idx]};
  assign w_q_hs      = mst_q_valid && mst_q_ready;

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      slv_q_ready[i] = w_gnt_any && (w_gnt_idx == IdxWidth'(i)) && mst_q_ready;
    end
  end

  assign w_p_idx = mst_p_id[OutIdWidth-1 -: IdxWidth];

  // Responses addressed past the last requester are swallowed.
  always_comb begin
    mst_p_ready  = 1'b1;
    w_p_in_range = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      slv_p_data[i]  = mst_p_data;
      slv_p_id[i]    = mst_p_id[IdWidth-1:0];
      slv_p_error[i] = mst_p_error;
      slv_p_valid[i] = mst_p_valid && (w_p_idx == IdxWidth'(i));
      if (w_p_idx == IdxWidth'(i)) begin
        w_p_in_range = 1'b1;
        mst_p_ready  = slv_p_ready[i];
      end
    end
  end

  assign w_p_hs = mst_p_valid && mst_p_ready && w_p_in_range;

  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      w_inc[i] = w_q_hs && (w_gnt_idx == IdxWidth'(i));
      w_dec[i] = w_p_hs && (w_p_idx == IdxWidth'(i)) && (r_cnt[i] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_q_hs) begin
        r_ptr  <= (w_gnt_idx == LastIdx) ? '0 : w_gnt_idx + 1'b1;
        r_lock <= 1'b0;
      end else if (mst_q_valid) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_gnt_idx;
      end
      for (int i = 0; i < NumReq; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (w_dec[i] && !w_inc[i]) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_arbiter.sv
// Scoreboard bench for acc_arbiter: a 4-requester instance for arbitration/limits and a
// 3-requester instance for out-of-range response indices.
module tb_acc_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = 5;
  localparam int XW = 2;
  localparam int OW = IW + XW;

  typedef struct packed {
    logic [OW-1:0] id;
    logic [DW-1:0] arga;
  } req_exp_t;

  typedef struct packed {
    logic [XW-1:0] idx;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          err;
  } rsp_exp_t;

  logic clk;
  logic rst_n;

  logic [N-1:0][AW-1:0] slv_q_addr;
  logic [N-1:0][31:0]   slv_q_op;
  logic [N-1:0][DW-1:0] slv_q_arga, slv_q_argb, slv_q_argc;
  logic [N-1:0][IW-1:0] slv_q_id;
  logic [N-1:0]         slv_q_valid, slv_q_ready;
  logic [N-1:0][DW-1:0] slv_p_data;
  logic [N-1:0][IW-1:0] slv_p_id;
  logic [N-1:0]         slv_p_error, slv_p_valid, slv_p_ready;
  logic [AW-1:0]        mst_q_addr;
  logic [31:0]          mst_q_op;
  logic [DW-1:0]        mst_q_arga, mst_q_argb, mst_q_argc;
  logic [OW-1:0]        mst_q_id;
  logic                 mst_q_valid, mst_q_ready;
  logic [DW-1:0]        mst_p_data;
  logic [OW-1:0]        mst_p_id;
  logic                 mst_p_error, mst_p_valid, mst_p_ready;

  logic [2:0][AW-1:0]   d3_slv_q_addr;
  logic [2:0][31:0]     d3_slv_q_op;
  logic [2:0][DW-1:0]   d3_slv_q_arga, d3_slv_q_argb, d3_slv_q_argc;
  logic [2:0][IW-1:0]   d3_slv_q_id;
  logic [2:0]           d3_slv_q_valid, d3_slv_q_ready;
  logic [2:0][DW-1:0]   d3_slv_p_data;
  logic [2:0][IW-1:0]   d3_slv_p_id;
  logic [2:0]           d3_slv_p_error, d3_slv_p_valid, d3_slv_p_ready;
  logic [AW-1:0]        d3_mst_q_addr;
  logic [31:0]          d3_mst_q_op;
  logic [DW-1:0]        d3_mst_q_arga, d3_mst_q_argb, d3_mst_q_argc;
  logic [OW-1:0]        d3_mst_q_id;
  logic                 d3_mst_q_valid, d3_mst_q_ready;
  logic [DW-1:0]        d3_mst_p_data;
  logic [OW-1:0]        d3_mst_p_id;
  logic                 d3_mst_p_error, d3_mst_p_valid, d3_mst_p_ready;

  int n_checks = 0;
  int n_fail   = 0;

  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];

  acc_arbiter #(
    .NumReq(N), .DataWidth(DW), .AccAddrWidth(AW), .IdWidth(IW), .MaxOutstanding(4)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_q_addr(slv_q_addr), .slv_q_op(slv_q_op), .slv_q_arga(slv_q_arga),
    .slv_q_argb(slv_q_argb), .slv_q_argc(slv_q_argc), .slv_q_id(slv_q_id),
    .slv_q_valid(slv_q_valid), .slv_q_ready(slv_q_ready),
    .slv_p_data(slv_p_data), .slv_p_id(slv_p_id), .slv_p_error(slv_p_error),
    .slv_p_valid(slv_p_valid), .slv_p_ready(slv_p_ready),
    .mst_q_addr(mst_q_addr), .mst_q_op(mst_q_op), .mst_q_arga(mst_q_arga),
    .mst_q_argb(mst_q_argb), .mst_q_argc(mst_q_argc), .mst_q_id(mst_q_id),
    .mst_q_valid(mst_q_valid), .mst_q_ready(mst_q_ready),
    .mst_p_data(mst_p_data), .mst_p_id(mst_p_id), .mst_p_error(mst_p_error),
    .mst_p_valid(mst_p_valid), .mst_p_ready(mst_p_ready)
  );

  acc_arbiter #(
    .NumReq(3), .DataWidth(DW), .AccAddrWidth(AW), .IdWidth(IW), .MaxOutstanding(4)
  ) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_q_addr(d3_slv_q_addr), .slv_q_op(d3_slv_q_op), .slv_q_arga(d3_slv_q_arga),
    .slv_q_argb(d3_slv_q_argb), .slv_q_argc(d3_slv_q_argc), .slv_q_id(d3_slv_q_id),
    .slv_q_valid(d3_slv_q_valid), .slv_q_ready(d3_slv_q_ready),
    .slv_p_data(d3_slv_p_data), .slv_p_id(d3_slv_p_id), .slv_p_error(d3_slv_p_error),
    .slv_p_valid(d3_slv_p_valid), .slv_p_ready(d3_slv_p_ready),
    .mst_q_addr(d3_mst_q_addr), .mst_q_op(d3_mst_q_op), .mst_q_arga(d3_mst_q_arga),
    .mst_q_argb(d3_mst_q_argb), .mst_q_argc(d3_mst_q_argc), .mst_q_id(d3_mst_q_id),
    .mst_q_valid(d3_mst_q_valid), .mst_q_ready(d3_mst_q_ready),
    .mst_p_data(d3_mst_p_data), .mst_p_id(d3_mst_p_id), .mst_p_error(d3_mst_p_error),
    .mst_p_valid(d3_mst_p_valid), .mst_p_ready(d3_mst_p_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] arg_of(input int i, input logic [IW-1:0] id);
    return 32'hA000_0000 + DW'(i * 256) + DW'(id);
  endfunction

  task automatic set_req(input int i, input logic [IW-1:0] id);
    slv_q_id[i]   = id;
    slv_q_arga[i] = arg_of(i, id);
    slv_q_argb[i] = ~arg_of(i, id);
    slv_q_argc[i] = arg_of(i, id) ^ 32'h5555_5555;
    slv_q_addr[i] = AW'(i) ^ id;
    slv_q_op[i]   = 32'h0000_0100 + 32'(id);
  endtask

  task automatic push_req(input int i, input logic [IW-1:0] id);
    req_exp_t e;
    e.id   = {XW'(i), id};
    e.arga = arg_of(i, id);
    req_q.push_back(e);
  endtask

  task automatic drive_rsp(input int idx, input logic [IW-1:0] id, input logic [DW-1:0] data,
                           input logic err);
    mst_p_id    = {XW'(idx), id};
    mst_p_data  = data;
    mst_p_error = err;
    mst_p_valid = 1'b1;
  endtask

  task automatic push_rsp(input int idx, input logic [IW-1:0] id, input logic [DW-1:0] data,
                          input logic err);
    rsp_exp_t e;
    e.idx  = XW'(idx);
    e.id   = id;
    e.data = data;
    e.err  = err;
    rsp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Scoreboard: every handshake on either side must match the oldest expected entry.
  always @(negedge clk) begin
    req_exp_t qe;
    rsp_exp_t pe;
    if (mst_q_valid && mst_q_ready) begin
      check_eq("req_pending", 64'(req_q.size() != 0), 64'd1);
      if (req_q.size() != 0) begin
        qe = req_q.pop_front();
        check_eq("req_id", 64'(mst_q_id), 64'(qe.id));
        check_eq("req_arga", 64'(mst_q_arga), 64'(qe.arga));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (slv_p_valid[i] && slv_p_ready[i]) begin
        check_eq("rsp_pending", 64'(rsp_q.size() != 0), 64'd1);
        if (rsp_q.size() != 0) begin
          pe = rsp_q.pop_front();
          check_eq("rsp_idx", 64'(i), 64'(pe.idx));
          check_eq("rsp_id", 64'(slv_p_id[i]), 64'(pe.id));
          check_eq("rsp_data", 64'(slv_p_data[i]), 64'(pe.data));
          check_eq("rsp_err", 64'(slv_p_error[i]), 64'(pe.err));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    slv_q_addr = '0; slv_q_op = '0; slv_q_arga = '0; slv_q_argb = '0; slv_q_argc = '0;
    slv_q_id = '0; slv_q_valid = '0; slv_p_ready = '0; mst_q_ready = 1'b0;
    mst_p_data = '0; mst_p_id = '0; mst_p_error = 1'b0; mst_p_valid = 1'b0;
    d3_slv_q_addr = '0; d3_slv_q_op = '0; d3_slv_q_arga = '0; d3_slv_q_argb = '0;
    d3_slv_q_argc = '0; d3_slv_q_id = '0; d3_slv_q_valid = '0; d3_slv_p_ready = '0;
    d3_mst_q_ready = 1'b0; d3_mst_p_data = '0; d3_mst_p_id = '0; d3_mst_p_error = 1'b0;
    d3_mst_p_valid = 1'b0;
    #1;
    do_reset();

    // Idle after reset
    @(negedge clk);
    check_eq("rst_q_valid", 64'(mst_q_valid), 64'd0);
    check_eq("rst_q_ready", 64'(slv_q_ready), 64'd0);
    check_eq("rst_p_valid", 64'(slv_p_valid), 64'd0);
    next_cycle();

    // All four requesting, accelerator always ready: 0,1,2,3,0
    for (int i = 0; i < N; i++) set_req(i, IW'(i + 1));
    slv_q_valid = 4'hF;
    mst_q_ready = 1'b1;
    push_req(0, 5'd1); push_req(1, 5'd2); push_req(2, 5'd3); push_req(3, 5'd4); push_req(0, 5'd1);
    repeat (5) next_cycle();
    slv_q_valid = '0;
    mst_q_ready = 1'b0;

    // Lock: requester 2 stalled, requester 1 arrives later but must wait
    do_reset();
    set_req(2, 5'd7);
    slv_q_valid[2] = 1'b1;
    @(negedge clk);
    check_eq("lock_c0_valid", 64'(mst_q_valid), 64'd1);
    check_eq("lock_c0_id", 64'(mst_q_id), 64'({2'd2, 5'd7}));
    next_cycle();
    set_req(1, 5'd9);
    slv_q_valid[1] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("lock_hold_id", 64'(mst_q_id), 64'({2'd2, 5'd7}));
      check_eq("lock_hold_arga", 64'(mst_q_arga), 64'(arg_of(2, 5'd7)));
      check_eq("lock_hold_valid", 64'(mst_q_valid), 64'd1);
      next_cycle();
    end
    mst_q_ready = 1'b1;
    push_req(2, 5'd7);
    @(negedge clk);
    check_eq("lock_hs_ready", 64'(slv_q_ready), 64'b0100);
    next_cycle();
    slv_q_valid[2] = 1'b0;
    push_req(1, 5'd9);
    @(negedge clk);
    check_eq("lock_next_ready", 64'(slv_q_ready), 64'b0010);
    next_cycle();
    slv_q_valid[1] = 1'b0;
    mst_q_ready = 1'b0;

    // Outstanding limit on requester 0
    do_reset();
    mst_q_ready = 1'b1;
    slv_q_valid[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(0, IW'(k));
      push_req(0, IW'(k));
      next_cycle();
    end
    set_req(0, 5'd4);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("max_stall_ready", 64'(slv_q_ready[0]), 64'd0);
      check_eq("max_stall_valid", 64'(mst_q_valid), 64'd0);
      next_cycle();
    end
    drive_rsp(0, 5'h03, 32'hD00D_0003, 1'b0);
    slv_p_ready = 4'b0001;
    push_rsp(0, 5'h03, 32'hD00D_0003, 1'b0);
    push_req(0, 5'd4);
    @(negedge clk);
    check_eq("max_rsp_ready", 64'(mst_p_ready), 64'd1);
    check_eq("max_rsp_cycle_qrdy", 64'(slv_q_ready[0]), 64'd0);
    next_cycle();
    mst_p_valid = 1'b0;
    slv_p_ready = '0;
    @(negedge clk);
    check_eq("max_resume_ready", 64'(slv_q_ready[0]), 64'd1);
    next_cycle();
    slv_q_valid[0] = 1'b0;

    // Response backpressure to requester 3 with requester 3 saturated
    do_reset();
    slv_q_valid[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(3, IW'(16 + k));
      push_req(3, IW'(16 + k));
      next_cycle();
    end
    set_req(3, 5'd20);
    drive_rsp(3, 5'h0A, 32'hCAFE_000A, 1'b0);
    slv_p_ready = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("bp_p_ready", 64'(mst_p_ready), 64'd0);
      check_eq("bp_p_valid", 64'(slv_p_valid), 64'b1000);
      check_eq("bp_p_id", 64'(slv_p_id[3]), 64'h0A);
      check_eq("bp_q_ready", 64'(slv_q_ready[3]), 64'd0);
      next_cycle();
    end
    slv_p_ready = 4'b1000;
    push_rsp(3, 5'h0A, 32'hCAFE_000A, 1'b0);
    push_req(3, 5'd20);
    @(negedge clk);
    check_eq("bp_hs_p_ready", 64'(mst_p_ready), 64'd1);
    check_eq("bp_hs_q_ready", 64'(slv_q_ready[3]), 64'd0);
    next_cycle();
    mst_p_valid = 1'b0;
    slv_p_ready = '0;
    @(negedge clk);
    check_eq("bp_after_q_ready", 64'(slv_q_ready[3]), 64'd1);
    next_cycle();
    set_req(3, 5'd21);

    // Reset while locked on requester 2 and requester 3 saturated
    mst_q_ready = 1'b0;
    set_req(2, 5'd5);
    slv_q_valid[2] = 1'b1;
    @(negedge clk);
    check_eq("rl_gnt", 64'(mst_q_id), 64'({2'd2, 5'd5}));
    next_cycle();
    set_req(0, 5'd6);
    slv_q_valid[0] = 1'b1;
    @(negedge clk);
    check_eq("rl_locked", 64'(mst_q_id), 64'({2'd2, 5'd5}));
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rl_in_rst_valid", 64'(mst_q_valid), 64'd1);
    check_eq("rl_in_rst_id", 64'(mst_q_id), 64'({2'd2, 5'd5}));
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rl_after_id", 64'(mst_q_id), 64'({2'd0, 5'd6}));
    mst_q_ready = 1'b1;
    push_req(0, 5'd6); push_req(2, 5'd5); push_req(3, 5'd21);
    next_cycle();
    slv_q_valid[0] = 1'b0;
    next_cycle();
    slv_q_valid[2] = 1'b0;
    next_cycle();
    slv_q_valid[3] = 1'b0;
    mst_q_ready = 1'b0;

    // Response to a requester with nothing outstanding is still forwarded
    drive_rsp(1, 5'h11, 32'h1234_5678, 1'b1);
    slv_p_ready = 4'b0010;
    push_rsp(1, 5'h11, 32'h1234_5678, 1'b1);
    @(negedge clk);
    check_eq("zero_cnt_p_ready", 64'(mst_p_ready), 64'd1);
    next_cycle();
    mst_p_valid = 1'b0;
    slv_p_ready = '0;

    // Three-requester instance: index 3 is out of range
    d3_mst_p_id    = {2'd3, 5'h01};
    d3_mst_p_data  = 32'hBAD0_0001;
    d3_mst_p_valid = 1'b1;
    @(negedge clk);
    check_eq("oor_p_ready", 64'(d3_mst_p_ready), 64'd1);
    check_eq("oor_p_valid", 64'(d3_slv_p_valid), 64'd0);
    next_cycle();
    d3_mst_p_id = {2'd1, 5'h02};
    @(negedge clk);
    check_eq("inr_p_ready", 64'(d3_mst_p_ready), 64'd0);
    check_eq("inr_p_valid", 64'(d3_slv_p_valid), 64'b010);
    check_eq("inr_p_id", 64'(d3_slv_p_id[1]), 64'h02);
    next_cycle();
    d3_mst_p_valid = 1'b0;

    repeat (2) next_cycle();
    check_eq("req_q_left", 64'(req_q.size()), 64'd0);
    check_eq("rsp_q_left", 64'(rsp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
